// File: rtl/uart_frame_loader_pkg.sv
// Shared types and constants for the UART receive-side frame loader.
//   loader_state_t : frame loader FSM states
//   err_code_t     : error code reported on err_code
//   DEFAULT_SYNC_BYTE, BAUD_CLKS, DEFAULT_TIMEOUT_CLKS : default timing/marker values
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIXELS = 2'd1,
        CHECK  = 2'd2,
        HOLD   = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE    = 8'hA5;
    localparam int unsigned BAUD_CLKS            = 54;
    // Four byte-times of 10 baud periods each (start + 8 data + stop).
    localparam int unsigned DEFAULT_TIMEOUT_CLKS = 4 * 10 * BAUD_CLKS;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Bundles the byte stream, image-RAM write port and detector handshake of
// the frame loader.
//   master : the loader (consumes uart_data/uart_data_rdy/frame_ack,
//            drives mem_*, frame_valid, frame_err, err_code, busy)
//   slave  : the surrounding system (receiver, RAM, detector)
interface uart_frame_loader_if #(
    parameter int unsigned ADDR_W = 11
);
    logic [7:0]        uart_data;
    logic              uart_data_rdy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              frame_valid;
    logic              frame_ack;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        input  uart_data, uart_data_rdy, frame_ack,
        output mem_we, mem_addr, mem_wdata, frame_valid, frame_err, err_code, busy
    );

    modport slave (
        output uart_data, uart_data_rdy, frame_ack,
        input  mem_we, mem_addr, mem_wdata, frame_valid, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_frame_loader_timeout_ctr.sv
// Loadable down-counter used as an inter-byte watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : force count to zero (highest priority)
//   load_i        : load load_val_i
//   load_val_i    : reload value
//   en_i          : count down while enabled and non-zero
//   expired_o     : high in the cycle whose decrement reaches zero
module frame_timeout_ctr #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Loaded with N, this fires on the Nth enabled clock after the load.
    assign expired_o = en_i && (count_q == WIDTH'(1));

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader: finds the sync byte, writes IMG_W*IMG_H greyscale
// pixels into image RAM in row-major order, verifies the trailing 8-bit
// checksum and offers the frame to the detector with frame_valid/frame_ack.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (master)   : uart_data/uart_data_rdy in, mem_we/mem_addr/mem_wdata out,
//                    frame_valid out / frame_ack in, frame_err, err_code, busy out
module uart_frame_loader
    import uart_pkg::*;
#(
    parameter int unsigned IMG_W        = 40,
    parameter int unsigned IMG_H        = 30,
    parameter int unsigned NUM_PIX      = IMG_W * IMG_H,
    parameter int unsigned ADDR_W       = $clog2(NUM_PIX),
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  logic                clock,
    input  logic                reset_n,
    uart_frame_loader_if.master bus
);
    // One extra bit so the counter can hold NUM_PIX when it is a power of 2.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

    loader_state_t     state_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [7:0]        csum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              frame_valid_q;
    logic              frame_err_q;
    err_code_t         err_q;

    logic rdy;
    logic is_sync;
    logic tmr_en;
    logic tmr_load;
    logic tmr_clear;
    logic tmr_expired;

    always_comb begin
        rdy     = bus.uart_data_rdy;
        is_sync = (bus.uart_data == SYNC_BYTE);
        tmr_en  = (state_q == PIXELS) || (state_q == CHECK);
        // Every accepted byte restarts the watchdog, including the sync byte.
        tmr_load  = rdy && (tmr_en || ((state_q == IDLE) && is_sync));
        tmr_clear = !tmr_en && !tmr_load;
    end

    frame_timeout_ctr #(
        .WIDTH(TMR_W)
    ) u_timeout (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TIMEOUT_CLKS)),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pix_cnt_q     <= '0;
            csum_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_q         <= ERR_NONE;
        end else begin
            mem_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rdy && is_sync) begin
                        state_q   <= PIXELS;
                        pix_cnt_q <= '0;
                        csum_q    <= '0;
                        err_q     <= ERR_NONE;
                    end
                end
                PIXELS: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rdy) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= pix_cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= bus.uart_data;
                        csum_q      <= csum_q + bus.uart_data;
                        pix_cnt_q   <= pix_cnt_q + 1'b1;
                        if (pix_cnt_q == CNT_W'(NUM_PIX - 1)) begin
                            state_q <= CHECK;
                        end
                    end else if (tmr_expired) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_TIMEOUT;
                        state_q     <= IDLE;
                    end
                end
                CHECK: begin
                    if (rdy) begin
                        if (bus.uart_data == csum_q) begin
                            frame_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_q       <= ERR_CSUM;
                            state_q     <= IDLE;
                        end
                    end else if (tmr_expired) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_TIMEOUT;
                        state_q     <= IDLE;
                    end
                end
                HOLD: begin
                    if (rdy) begin
                        err_q <= ERR_OVERRUN;
                    end
                    if (bus.frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_code    = err_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with an 4x2 frame.
module tb_uart_frame_loader;
    import uart_pkg::*;

    localparam int unsigned T = DEFAULT_TIMEOUT_CLKS;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    int         wr_cnt = 0;
    int         err_pulses = 0;
    logic [2:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    always #5 clock = ~clock;

    uart_frame_loader_if #(.ADDR_W(3)) bus ();

    uart_frame_loader #(
        .IMG_W  (4),
        .IMG_H  (2),
        .ADDR_W (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Write / error-pulse log, sampled shortly after each rising edge.
    always @(posedge clock) begin
        #2;
        if (bus.mem_we === 1'b1) begin
            wr_cnt++;
            wr_addr_log.push_back(bus.mem_addr);
            wr_data_log.push_back(bus.mem_wdata);
        end
        if (bus.frame_err === 1'b1) err_pulses++;
    end

    // One-cycle rdy strobe; returns on the falling edge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.uart_data     = b;
        bus.uart_data_rdy = 1'b1;
        @(negedge clock);
        bus.uart_data_rdy = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        bus.frame_ack = 1'b1;
        @(negedge clock);
        bus.frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 3'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 00", bus.mem_wdata); end
        checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", bus.frame_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b expected 00", bus.err_code); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_good_frame();
        int bw;
        bw = wr_cnt;
        send_byte(8'hA5);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_sync_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL good_sync_no_write: got %b expected 0", bus.mem_we); end
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL good_we[%0d]: got %b expected 1", i, bus.mem_we); end
            checks++; if (bus.mem_addr !== 3'(i - 1)) begin errors++; $display("FAIL good_addr[%0d]: got %h expected %h", i, bus.mem_addr, 3'(i - 1)); end
            checks++; if (bus.mem_wdata !== 8'(i)) begin errors++; $display("FAIL good_data[%0d]: got %h expected %h", i, bus.mem_wdata, 8'(i)); end
        end
        checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL good_valid_early: got %b expected 0", bus.frame_valid); end
        send_byte(8'h24);
        checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", bus.frame_valid); end
        checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL good_err_code: got %b expected 00", bus.err_code); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL good_csum_no_write: got %b expected 0", bus.mem_we); end
        checks++; if (wr_cnt - bw !== 8) begin errors++; $display("FAIL good_write_count: got %0d expected 8", wr_cnt - bw); end
        ack_pulse();
        checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL good_valid_after_ack: got %b expected 0", bus.frame_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_busy_after_ack: got %b expected 0", bus.busy); end
    endtask

    task automatic test_bad_checksum();
        int bw;
        int be;
        bw = wr_cnt;
        be = err_pulses;
        send_byte(8'hA5);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h25);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL csum_err_pulse: got %b expected 1", bus.frame_err); end
        checks++; if (bus.err_code !== 2'b01) begin errors++; $display("FAIL csum_err_code: got %b expected 01", bus.err_code); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL csum_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL csum_valid: got %b expected 0", bus.frame_valid); end
        @(negedge clock);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL csum_err_width: got %b expected 0", bus.frame_err); end
        checks++; if (err_pulses - be !== 1) begin errors++; $display("FAIL csum_err_count: got %0d expected 1", err_pulses - be); end
        checks++; if (wr_cnt - bw !== 8) begin errors++; $display("FAIL csum_write_count: got %0d expected 8", wr_cnt - bw); end
    endtask

    task automatic test_timeout();
        int bw;
        int be;
        bw = wr_cnt;
        be = err_pulses;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        // Last rdy was sampled 5 time units ago; expiry lands T edges after it.
        repeat (T - 1) @(negedge clock);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_early_busy: got %b expected 1", bus.busy); end
        @(negedge clock);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse: got %b expected 1", bus.frame_err); end
        checks++; if (bus.err_code !== 2'b10) begin errors++; $display("FAIL tmo_err_code: got %b expected 10", bus.err_code); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", bus.busy); end
        @(negedge clock);
        checks++; if (err_pulses - be !== 1) begin errors++; $display("FAIL tmo_err_count: got %0d expected 1", err_pulses - be); end
        checks++; if (wr_cnt - bw !== 2) begin errors++; $display("FAIL tmo_write_count: got %0d expected 2", wr_cnt - bw); end
        send_byte(8'hA5);
        checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL tmo_restart_err_code: got %b expected 00", bus.err_code); end
        send_byte(8'h01);
        checks++; if (bus.mem_addr !== 3'd0 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL tmo_restart_addr: got we=%b addr=%h expected we=1 addr=0", bus.mem_we, bus.mem_addr); end
    endtask

    // Continues the frame left open by test_timeout.
    task automatic test_rdy_vs_timeout();
        int be;
        be = err_pulses;
        repeat (T - 2) @(negedge clock);
        send_byte(8'h02);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 3'd1) begin errors++; $display("FAIL race_write: got we=%b addr=%h expected we=1 addr=1", bus.mem_we, bus.mem_addr); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL race_no_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL race_busy: got %b expected 1", bus.busy); end
        for (int i = 3; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h24);
        checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL race_valid: got %b expected 1", bus.frame_valid); end
        checks++; if (err_pulses - be !== 0) begin errors++; $display("FAIL race_err_count: got %0d expected 0", err_pulses - be); end
        ack_pulse();
    endtask

    task automatic test_presync_and_a5_pixel();
        int bw;
        logic [7:0] pix [8];
        pix = '{8'h01, 8'h02, 8'hA5, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        bw = wr_cnt;
        send_byte(8'h00);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL presync_00_busy: got %b expected 0", bus.busy); end
        send_byte(8'hFF);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL presync_ff_busy: got %b expected 0", bus.busy); end
        checks++; if (wr_cnt - bw !== 0) begin errors++; $display("FAIL presync_writes: got %0d expected 0", wr_cnt - bw); end
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) begin
            send_byte(pix[i]);
            checks++; if (bus.mem_addr !== 3'(i) || bus.mem_wdata !== pix[i]) begin errors++; $display("FAIL a5pix[%0d]: got addr=%h data=%h expected addr=%h data=%h", i, bus.mem_addr, bus.mem_wdata, 3'(i), pix[i]); end
        end
        send_byte(8'hC6);
        checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL a5pix_valid: got %b expected 1", bus.frame_valid); end
        checks++; if (wr_cnt - bw !== 8) begin errors++; $display("FAIL a5pix_write_count: got %0d expected 8", wr_cnt - bw); end
    endtask

    // Starts in HOLD, left there by test_presync_and_a5_pixel.
    task automatic test_overrun_in_hold();
        int bw;
        int be;
        bw = wr_cnt;
        be = err_pulses;
        send_byte(8'h33);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL ovr_no_write: got %b expected 0", bus.mem_we); end
        checks++; if (bus.err_code !== 2'b11) begin errors++; $display("FAIL ovr_err_code: got %b expected 11", bus.err_code); end
        checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.frame_valid); end
        send_byte(8'hA5);
        checks++; if (bus.busy !== 1'b1 || bus.frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_sync_ignored: got busy=%b valid=%b expected 1 1", bus.busy, bus.frame_valid); end
        checks++; if (wr_cnt - bw !== 0 || err_pulses - be !== 0) begin errors++; $display("FAIL ovr_side_effects: got writes=%0d errs=%0d expected 0 0", wr_cnt - bw, err_pulses - be); end
        ack_pulse();
        checks++; if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_ack: got valid=%b busy=%b expected 0 0", bus.frame_valid, bus.busy); end
        checks++; if (bus.err_code !== 2'b11) begin errors++; $display("FAIL ovr_code_held: got %b expected 11", bus.err_code); end
    endtask

    task automatic test_reset_midframe();
        int bw;
        bw = wr_cnt;
        send_byte(8'hA5);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        checks++; if (wr_cnt - bw !== 4) begin errors++; $display("FAIL rst_pre_writes: got %0d expected 4", wr_cnt - bw); end
        @(negedge clock);
        bus.uart_data     = 8'h05;
        bus.uart_data_rdy = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_async_flags: got busy=%b valid=%b err=%b expected 0 0 0", bus.busy, bus.frame_valid, bus.frame_err); end
        checks++; if (bus.mem_addr !== 3'd0 || bus.mem_wdata !== 8'h00 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_async_mem: got we=%b addr=%h data=%h expected 0 0 00", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL rst_async_code: got %b expected 00", bus.err_code); end
        reset_n = 1'b1;
        @(negedge clock);
        bus.uart_data_rdy = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (wr_cnt - bw !== 4 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_aborted: got writes=%0d busy=%b expected 4 0", wr_cnt - bw, bus.busy); end
        bw = wr_cnt;
        send_byte(8'hA5);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h24);
        checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL rst_reload_valid: got %b expected 1", bus.frame_valid); end
        checks++; if (wr_cnt - bw !== 8) begin errors++; $display("FAIL rst_reload_count: got %0d expected 8", wr_cnt - bw); end
        for (int i = 0; i < 8 && (bw + i) < wr_cnt; i++) begin
            checks++; if (wr_addr_log[bw + i] !== 3'(i) || wr_data_log[bw + i] !== 8'(i + 1)) begin errors++; $display("FAIL rst_reload[%0d]: got addr=%h data=%h expected addr=%h data=%h", i, wr_addr_log[bw + i], wr_data_log[bw + i], 3'(i), 8'(i + 1)); end
        end
        ack_pulse();
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.uart_data     = 8'h00;
        bus.uart_data_rdy = 1'b0;
        bus.frame_ack     = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_rdy_vs_timeout();
        test_presync_and_a5_pixel();
        test_overrun_in_hold();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
